// File: rtl/hw_accel_frame_ctrl.sv
// hw_accel_frame_ctrl: per-frame flush/kick/run sequencer with pixel counting, stall and overrun detection
module hw_accel_frame_ctrl #(
    parameter int FRAME_WIDTH = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int RST_PULSE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    localparam int N = FRAME_WIDTH * FRAME_HEIGHT,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont_mode,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             out_valid,
    output logic             accel_rst,
    output logic             dma_kick,
    output logic             write_en,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic             err_timeout,
    output logic             err_overrun,
    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int RST_W = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] N_MAX = CNT_W'(N);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_PULSE_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, FLUSH, KICK, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic start_q, term_q, term_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] in_count_q, in_count_d, out_count_q, out_count_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic err_timeout_q, err_timeout_d, err_overrun_q, err_overrun_d;
    logic accel_rst_q, accel_rst_d, dma_kick_q, dma_kick_d, write_en_q, write_en_d;
    logic busy_q, busy_d, frame_done_q, frame_done_d;
    always_comb begin
        state_d = state_q;
        term_d = term_q;
        rst_cnt_d = '0;
        timer_d = timer_q;
        in_count_d = in_count_q;
        out_count_d = out_count_q;
        frame_count_d = frame_count_q;
        err_timeout_d = err_timeout_q;
        err_overrun_d = err_overrun_q;
        case (state_q)
            IDLE: if (start && !start_q) begin
                state_d = FLUSH;
                term_d = 1'b0;
            end
            FLUSH: begin
                in_count_d = '0;
                out_count_d = '0;
                timer_d = '0;
                rst_cnt_d = rst_cnt_q + RST_W'(1);
                // a flush caused by abort/timeout ends the frame instead of re-kicking
                if (rst_cnt_q == RST_LAST) state_d = term_q ? IDLE : KICK;
            end
            KICK: state_d = RUN;
            RUN: begin
                if (in_valid) begin
                    if (in_count_q == N_MAX) err_overrun_d = 1'b1;
                    else in_count_d = in_count_q + CNT_W'(1);
                end
                if (out_valid) out_count_d = out_count_q + CNT_W'(1);
                timer_d = out_valid ? '0 : timer_q + TMR_W'(1);
                if (abort) begin
                    state_d = FLUSH;
                    term_d = 1'b1;
                end else if (out_valid && out_count_q == N_LAST) begin
                    state_d = DONE;
                    frame_count_d = frame_count_q + 16'd1;
                end else if (!out_valid && timer_q == TMR_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d = FLUSH;
                    term_d = 1'b1;
                end
            end
            DONE: begin
                state_d = (cont_mode && !abort) ? FLUSH : IDLE;
                term_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        accel_rst_d = state_d == FLUSH;
        dma_kick_d = state_d == KICK;
        write_en_d = state_d == RUN;
        busy_d = state_d != IDLE;
        frame_done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            term_q <= 1'b0;
            rst_cnt_q <= '0;
            timer_q <= '0;
            in_count_q <= '0;
            out_count_q <= '0;
            frame_count_q <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            accel_rst_q <= 1'b0;
            dma_kick_q <= 1'b0;
            write_en_q <= 1'b0;
            busy_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            term_q <= term_d;
            rst_cnt_q <= rst_cnt_d;
            timer_q <= timer_d;
            in_count_q <= in_count_d;
            out_count_q <= out_count_d;
            frame_count_q <= frame_count_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
            accel_rst_q <= accel_rst_d;
            dma_kick_q <= dma_kick_d;
            write_en_q <= write_en_d;
            busy_q <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end
    assign accel_rst = accel_rst_q;
    assign dma_kick = dma_kick_q;
    assign write_en = write_en_q;
    assign busy = busy_q;
    assign frame_done = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
    assign in_count = in_count_q;
    assign out_count = out_count_q;
endmodule

// File: tb/tb_hw_accel_frame_ctrl.sv
// tb_hw_accel_frame_ctrl: directed vector table plus multi-cycle sequences for the frame sequencer
module tb_hw_accel_frame_ctrl;
    localparam int W = 4, H = 2, R = 4, T = 32, N = W * H, CW = $clog2(N + 1);
    logic clk = 0, rst_n = 1, start = 0, cont_mode = 0, abort = 0, in_valid = 0, out_valid = 0;
    logic accel_rst, dma_kick, write_en, busy, frame_done, err_timeout, err_overrun;
    logic [15:0] frame_count;
    logic [CW-1:0] in_count, out_count;
    int passed = 0, total = 0;
    typedef struct {
        logic st, cm, ab, iv, ov;
        logic ar, dk, we, bz, fd;
        int fc, ic, oc;
        logic et, eo;
    } vec_t;
    vec_t vecs[17];
    hw_accel_frame_ctrl #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .RST_PULSE_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont_mode(cont_mode), .abort(abort),
        .in_valid(in_valid), .out_valid(out_valid), .accel_rst(accel_rst), .dma_kick(dma_kick),
        .write_en(write_en), .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .in_count(in_count), .out_count(out_count)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(input logic st, input logic cm, input logic ab, input logic iv, input logic ov,
                                input logic ar, input logic dk, input logic we, input logic bz, input logic fd,
                                input int fc, input int ic, input int oc, input logic et, input logic eo);
        vec_t v;
        v.st = st; v.cm = cm; v.ab = ab; v.iv = iv; v.ov = ov;
        v.ar = ar; v.dk = dk; v.we = we; v.bz = bz; v.fd = fd;
        v.fc = fc; v.ic = ic; v.oc = oc; v.et = et; v.eo = eo;
        return v;
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_flush(input string tag);
        for (int i = 0; i < R; i++) begin
            step();
            chk({tag, ".accel_rst"}, accel_rst, 1);
            if (i == 0) chk({tag, ".frame_done_pulse"}, frame_done, 0);
        end
        step();
        chk({tag, ".dma_kick"}, dma_kick, 1);
        chk({tag, ".accel_rst_end"}, accel_rst, 0);
        step();
        chk({tag, ".dma_kick_pulse"}, dma_kick, 0);
        chk({tag, ".write_en"}, write_en, 1);
    endtask
    task automatic pixels(input int n);
        out_valid = 1;
        repeat (n) step();
        out_valid = 0;
    endtask
    task automatic apply_reset(input string tag);
        rst_n = 0;
        #2;
        chk({tag, ".accel_rst"}, accel_rst, 0);
        chk({tag, ".dma_kick"}, dma_kick, 0);
        chk({tag, ".write_en"}, write_en, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".frame_done"}, frame_done, 0);
        chk({tag, ".frame_count"}, frame_count, 0);
        chk({tag, ".in_count"}, in_count, 0);
        chk({tag, ".out_count"}, out_count, 0);
        chk({tag, ".err_timeout"}, err_timeout, 0);
        chk({tag, ".err_overrun"}, err_overrun, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int k;
        logic seen_fd;
        vecs[0]  = mk(1,0,0,0,0, 1,0,0,1,0, 0,0,0, 0,0);
        vecs[1]  = mk(1,0,0,0,0, 1,0,0,1,0, 0,0,0, 0,0);
        vecs[2]  = mk(0,0,0,0,0, 1,0,0,1,0, 0,0,0, 0,0);
        vecs[3]  = mk(0,0,0,0,0, 1,0,0,1,0, 0,0,0, 0,0);
        vecs[4]  = mk(0,0,0,0,0, 0,1,0,1,0, 0,0,0, 0,0);
        vecs[5]  = mk(0,0,0,0,0, 0,0,1,1,0, 0,0,0, 0,0);
        vecs[6]  = mk(0,0,0,1,1, 0,0,1,1,0, 0,1,1, 0,0);
        vecs[7]  = mk(0,0,0,1,1, 0,0,1,1,0, 0,2,2, 0,0);
        vecs[8]  = mk(0,0,0,1,1, 0,0,1,1,0, 0,3,3, 0,0);
        vecs[9]  = mk(0,0,0,1,1, 0,0,1,1,0, 0,4,4, 0,0);
        vecs[10] = mk(0,0,0,1,0, 0,0,1,1,0, 0,5,4, 0,0);
        vecs[11] = mk(0,0,0,1,1, 0,0,1,1,0, 0,6,5, 0,0);
        vecs[12] = mk(0,0,0,1,1, 0,0,1,1,0, 0,7,6, 0,0);
        vecs[13] = mk(0,0,0,1,1, 0,0,1,1,0, 0,8,7, 0,0);
        vecs[14] = mk(0,0,0,0,1, 0,0,0,1,1, 1,8,8, 0,0);
        vecs[15] = mk(0,0,0,1,1, 0,0,0,0,0, 1,8,8, 0,0);
        vecs[16] = mk(0,0,0,1,1, 0,0,0,0,0, 1,8,8, 0,0);
        #1;
        apply_reset("reset");
        for (int i = 0; i < 17; i++) begin
            start = vecs[i].st; cont_mode = vecs[i].cm; abort = vecs[i].ab;
            in_valid = vecs[i].iv; out_valid = vecs[i].ov;
            step();
            chk($sformatf("v%0d.accel_rst", i), accel_rst, vecs[i].ar);
            chk($sformatf("v%0d.dma_kick", i), dma_kick, vecs[i].dk);
            chk($sformatf("v%0d.write_en", i), write_en, vecs[i].we);
            chk($sformatf("v%0d.busy", i), busy, vecs[i].bz);
            chk($sformatf("v%0d.frame_done", i), frame_done, vecs[i].fd);
            chk($sformatf("v%0d.frame_count", i), frame_count, vecs[i].fc);
            chk($sformatf("v%0d.in_count", i), in_count, vecs[i].ic);
            chk($sformatf("v%0d.out_count", i), out_count, vecs[i].oc);
            chk($sformatf("v%0d.err_timeout", i), err_timeout, vecs[i].et);
            chk($sformatf("v%0d.err_overrun", i), err_overrun, vecs[i].eo);
        end
        start = 0; in_valid = 0; out_valid = 0;
        apply_reset("reset2");
        cont_mode = 1;
        start = 1;
        expect_flush("cont.arm");
        start = 0;
        for (int f = 1; f <= 3; f++) begin
            pixels(8);
            chk($sformatf("cont%0d.frame_done", f), frame_done, 1);
            chk($sformatf("cont%0d.write_en", f), write_en, 0);
            chk($sformatf("cont%0d.frame_count", f), frame_count, f);
            expect_flush($sformatf("cont%0d.rearm", f));
        end
        pixels(4);
        cont_mode = 0;
        pixels(4);
        chk("cont4.frame_done", frame_done, 1);
        chk("cont4.frame_count", frame_count, 4);
        step();
        chk("cont4.busy", busy, 0);
        chk("cont4.accel_rst", accel_rst, 0);
        start = 1;
        expect_flush("stall.arm");
        start = 0;
        pixels(3);
        k = 0;
        seen_fd = 0;
        while (k < 40 && !err_timeout) begin
            step();
            k++;
            if (frame_done) seen_fd = 1;
        end
        chk("stall.cycles_to_err", k, 32);
        chk("stall.accel_rst", accel_rst, 1);
        chk("stall.write_en", write_en, 0);
        repeat (3) step();
        chk("stall.accel_rst4", accel_rst, 1);
        step();
        chk("stall.busy", busy, 0);
        chk("stall.no_kick", dma_kick, 0);
        chk("stall.no_frame_done", seen_fd, 0);
        chk("stall.frame_count", frame_count, 4);
        start = 1;
        expect_flush("restart.arm");
        start = 0;
        pixels(8);
        chk("restart.frame_done", frame_done, 1);
        chk("restart.frame_count", frame_count, 5);
        chk("restart.err_timeout", err_timeout, 1);
        step();
        start = 1;
        expect_flush("abort.arm");
        start = 0;
        pixels(5);
        chk("abort.out_count5", out_count, 5);
        abort = 1;
        out_valid = 1;
        step();
        abort = 0;
        out_valid = 0;
        chk("abort.write_en", write_en, 0);
        chk("abort.accel_rst", accel_rst, 1);
        chk("abort.frame_done", frame_done, 0);
        chk("abort.out_count6", out_count, 6);
        repeat (3) step();
        chk("abort.accel_rst4", accel_rst, 1);
        step();
        chk("abort.busy", busy, 0);
        chk("abort.no_kick", dma_kick, 0);
        chk("abort.frame_count", frame_count, 5);
        start = 1;
        expect_flush("ovr.arm");
        start = 0;
        in_valid = 1;
        repeat (8) step();
        chk("ovr.in_count8", in_count, 8);
        chk("ovr.err_before", err_overrun, 0);
        step();
        in_valid = 0;
        chk("ovr.in_count_sat", in_count, 8);
        chk("ovr.err_overrun", err_overrun, 1);
        abort = 1;
        step();
        abort = 0;
        repeat (4) step();
        chk("ovr.busy", busy, 0);
        in_valid = 1;
        step();
        in_valid = 0;
        chk("idle.in_count", in_count, 0);
        chk("idle.err_overrun", err_overrun, 1);
        start = 1;
        expect_flush("rst.arm");
        start = 0;
        pixels(3);
        chk("rst.out_count", out_count, 3);
        apply_reset("midrun");
        start = 1;
        expect_flush("post.arm");
        start = 0;
        pixels(8);
        chk("post.frame_done", frame_done, 1);
        chk("post.frame_count", frame_count, 1);
        step();
        chk("post.busy", busy, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
